// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the USB transmit scheduler.
package tx_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      ACTIVE     = 2'd2,
      GAP        = 2'd3
   } tx_sched_state_t;

   // Default timing parameters
   localparam int GAP_CYCLES_DEF    = 16;
   localparam int START_TIMEOUT_DEF = 8;

   // Bit positions inside the pending-request vector
   localparam int PEND_NAK  = 0;
   localparam int PEND_DATA = 1;

endpackage

// File: rtl/tx_scheduler.sv
// USB transmit scheduler: latches NAK/data requests from the receiver,
// issues single-cycle send commands, tracks the packet on the line via
// is_txing and enforces an inter-packet gap before the next command.
module tx_scheduler
   import tx_sched_pkg::*;
#(
   parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       nak_req,
   input  logic       data_req,
   input  logic       fifo_pkt_ready,
   input  logic       is_txing,
   output logic       send_nak,
   output logic       send_data,
   output logic       busy,
   output logic       tx_err,
   output logic [1:0] pending
);

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);

   tx_sched_state_t  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       pend_q, pend_d, pend_clr;
   logic             send_nak_q, send_nak_d;
   logic             send_data_q, send_data_d;
   logic             tx_err_q, tx_err_d;
   logic             busy_q, busy_d;

   // Saturating increment: the counter parks at its maximum instead of wrapping
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      if (c == CNT_MAX) begin
         return c;
      end else begin
         return c + CNT_ONE;
      end
   endfunction

   // Next-state, counter, command and pending-flag computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_clr    = 2'b00;
      send_nak_d  = 1'b0;
      send_data_d = 1'b0;
      tx_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (is_txing) begin
               // Transmitter already owns the line: hold commands until it is done
               state_d = ACTIVE;
               cnt_d   = CNT_ZERO;
            end else if (pend_q[PEND_NAK]) begin
               state_d            = WAIT_START;
               cnt_d              = CNT_ZERO;
               pend_clr[PEND_NAK] = 1'b1;
               send_nak_d         = 1'b1;
            end else if (pend_q[PEND_DATA]) begin
               // Without a complete payload in the FIFO the data request becomes a NAK
               state_d             = WAIT_START;
               cnt_d               = CNT_ZERO;
               pend_clr[PEND_DATA] = 1'b1;
               send_data_d         = fifo_pkt_ready;
               send_nak_d          = ~fifo_pkt_ready;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_START: begin
            if (is_txing) begin
               state_d = ACTIVE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q >= START_LAST) begin
               // Transmitter never started: report and drop the request, no gap
               state_d  = IDLE;
               cnt_d    = CNT_ZERO;
               tx_err_d = 1'b1;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ACTIVE: begin
            if (!is_txing) begin
               state_d = GAP;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = CNT_ZERO;
            end
         end
         GAP: begin
            if (is_txing) begin
               state_d = ACTIVE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q >= GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      // New requests always latch; a request arriving as its bit is served re-arms it
      pend_d = (pend_q & ~pend_clr) | {data_req, nak_req};
      busy_d = (state_d != IDLE) || (pend_d != 2'b00);
   end

   // State, counter, pending flags and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_ZERO;
         pend_q      <= 2'b00;
         send_nak_q  <= 1'b0;
         send_data_q <= 1'b0;
         tx_err_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         send_nak_q  <= send_nak_d;
         send_data_q <= send_data_d;
         tx_err_q    <= tx_err_d;
         busy_q      <= busy_d;
      end
   end

   assign send_nak  = send_nak_q;
   assign send_data = send_data_q;
   assign tx_err    = tx_err_q;
   assign busy      = busy_q;
   assign pending   = pend_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a countdown-based
// reference model plus spec-derived timing checks.
module tb_tx_scheduler;

   localparam int GAP = 16;
   localparam int TMO = 8;

   logic       clk;
   logic       n_rst;
   logic       nak_req;
   logic       data_req;
   logic       fifo_pkt_ready;
   logic       is_txing;
   logic       send_nak;
   logic       send_data;
   logic       busy;
   logic       tx_err;
   logic [1:0] pending;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: remaining-cycle counters instead of an explicit state
   int       m_wait;   // >0: waiting for the transmitter to start, cycles left
   int       m_gap;    // >0: inter-packet gap, cycles left
   bit       m_air;    // packet on the line
   bit [1:0] m_pend;   // {data, nak}
   bit       e_nak, e_data, e_err, e_busy;

   tx_scheduler #(
      .GAP_CYCLES    (GAP),
      .START_TIMEOUT (TMO),
      .CNT_W         (8)
   ) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .nak_req        (nak_req),
      .data_req       (data_req),
      .fifo_pkt_ready (fifo_pkt_ready),
      .is_txing       (is_txing),
      .send_nak       (send_nak),
      .send_data      (send_data),
      .busy           (busy),
      .tx_err         (tx_err),
      .pending        (pending)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_gap = 0; m_air = 1'b0; m_pend = 2'b00;
      e_nak = 1'b0; e_data = 1'b0; e_err = 1'b0; e_busy = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge
   task automatic model_edge();
      bit       idle;
      bit [1:0] srv;
      e_nak = 1'b0; e_data = 1'b0; e_err = 1'b0; srv = 2'b00;
      idle = (m_wait == 0) && !m_air && (m_gap == 0);
      if (idle) begin
         if (is_txing) begin
            m_air = 1'b1;
         end else if (m_pend[0]) begin
            srv = 2'b01; e_nak = 1'b1; m_wait = TMO;
         end else if (m_pend[1]) begin
            srv = 2'b10; m_wait = TMO;
            if (fifo_pkt_ready) e_data = 1'b1;
            else                e_nak  = 1'b1;
         end
      end else if (m_wait > 0) begin
         if (is_txing) begin
            m_wait = 0; m_air = 1'b1;
         end else if (m_wait == 1) begin
            m_wait = 0; e_err = 1'b1;
         end else begin
            m_wait--;
         end
      end else if (m_air) begin
         if (!is_txing) begin
            m_air = 1'b0; m_gap = GAP;
         end
      end else begin
         if (is_txing) begin
            m_gap = 0; m_air = 1'b1;
         end else begin
            m_gap--;
         end
      end
      m_pend = (m_pend & ~srv) | {data_req, nak_req};
      e_busy = (m_wait > 0) || m_air || (m_gap > 0) || (m_pend != 2'b00);
   endtask

   // One clock: model update at the edge, compare #1 later, drop request pulses
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("send_nak",  send_nak,  e_nak);
      chk("send_data", send_data, e_data);
      chk("tx_err",    tx_err,    e_err);
      chk("busy",      busy,      e_busy);
      chk("pending",   pending,   m_pend);
      chk("cmd_excl",  send_nak & send_data, 1'b0);
      nak_req  = 1'b0;
      data_req = 1'b0;
   endtask

   initial begin
      int first_at;
      int cnt_nak;
      int cnt_data;

      n_rst = 1'b0; nak_req = 1'b0; data_req = 1'b0;
      fifo_pkt_ready = 1'b1; is_txing = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_send_nak",  send_nak,  1'b0);
      chk("rst_send_data", send_data, 1'b0);
      chk("rst_busy",      busy,      1'b0);
      chk("rst_tx_err",    tx_err,    1'b0);
      chk("rst_pending",   pending,   2'b00);
      n_rst = 1'b1;

      // Scenario 1: NAK, 20-cycle packet, busy drops GAP clocks after the first idle-line edge
      repeat (4) step();
      nak_req = 1'b1;
      step();
      chk("s1_pend_set", pending, 2'b01);
      chk("s1_no_early", send_nak, 1'b0);
      step();
      chk("s1_send_nak", send_nak, 1'b1);
      chk("s1_pend_clr", pending, 2'b00);
      is_txing = 1'b1;
      repeat (20) step();
      chk("s1_nak_once", send_nak, 1'b0);
      is_txing = 1'b0;
      for (int i = 0; i < GAP; i++) begin
         step();
         chk("s1_busy_gap", busy, 1'b1);
      end
      step();
      chk("s1_busy_end", busy, 1'b0);

      // Scenario 2: simultaneous requests, NAK first, data after the gap
      nak_req = 1'b1; data_req = 1'b1; fifo_pkt_ready = 1'b1;
      step();
      chk("s2_pend_11", pending, 2'b11);
      step();
      chk("s2_nak_first", send_nak, 1'b1);
      chk("s2_pend_10", pending, 2'b10);
      is_txing = 1'b1;
      repeat (5) step();
      is_txing = 1'b0;
      first_at = -1; cnt_data = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (send_data) begin
            cnt_data++;
            if (first_at < 0) first_at = i;
         end
      end
      chk_int("s2_data_at", first_at, GAP + 2);
      chk_int("s2_data_cnt", cnt_data, 1);
      chk("s2_pend_00", pending, 2'b00);

      // Scenario 3: data request without a full payload turns into NAK
      fifo_pkt_ready = 1'b0; data_req = 1'b1;
      step();
      step();
      chk("s3_nak", send_nak, 1'b1);
      chk("s3_no_data", send_data, 1'b0);
      chk("s3_pend", pending, 2'b00);
      repeat (12) step();

      // Scenario 4: transmitter never starts, tx_err after TMO clocks
      fifo_pkt_ready = 1'b1; data_req = 1'b1;
      step();
      step();
      chk("s4_send_data", send_data, 1'b1);
      first_at = -1;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (tx_err && first_at < 0) begin
            first_at = i;
            chk("s4_busy_idle", busy, 1'b0);
         end
      end
      chk_int("s4_err_at", first_at, TMO);

      // Scenario 5: repeated data requests during ACTIVE merge, NAK in GAP waits
      is_txing = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         data_req = 1'b1;
         step();
         step();
      end
      chk("s5_pend_merge", pending, 2'b10);
      is_txing = 1'b0;
      repeat (3) step();
      nak_req = 1'b1;
      cnt_nak = 0; cnt_data = 0;
      for (int i = 0; i < GAP - 3; i++) begin
         step();
         if (send_nak || send_data) cnt_nak++;
      end
      chk_int("s5_none_in_gap", cnt_nak, 0);
      cnt_nak = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (send_nak)  cnt_nak++;
         if (send_data) cnt_data++;
      end
      chk_int("s5_nak_cnt", cnt_nak, 1);
      chk_int("s5_data_cnt", cnt_data, 1);

      // Scenario 6: async reset mid-ACTIVE with a NAK pending
      is_txing = 1'b1;
      repeat (3) step();
      nak_req = 1'b1;
      step();
      chk("s6_pend_01", pending, 2'b01);
      #3;
      n_rst = 1'b0;
      #1;
      model_reset();
      chk("s6_rst_nak",  send_nak,  1'b0);
      chk("s6_rst_data", send_data, 1'b0);
      chk("s6_rst_busy", busy,      1'b0);
      chk("s6_rst_err",  tx_err,    1'b0);
      chk("s6_rst_pend", pending,   2'b00);
      is_txing = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      cnt_nak = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (send_nak || send_data) cnt_nak++;
      end
      chk_int("s6_no_reissue", cnt_nak, 0);

      // Randomized phase against the reference model
      for (int i = 0; i < 3000; i++) begin
         nak_req        = ($urandom_range(0, 11) == 0);
         data_req       = ($urandom_range(0, 9) == 0);
         fifo_pkt_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) is_txing = ~is_txing;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
